// File: rtl/gcd.sv
// Binary (Stein's) GCD engine for two unsigned 32-bit operands.
// Start/done handshake; CALC performs one reduction step per clock.
module gcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] x_q, y_q, x_d, y_d;
  logic [5:0]  k_q, k_d;
  logic [31:0] result_q;
  logic        done_q;
  logic [31:0] diff_xy, diff_yx;

  // Next x/y/k for a non-terminating step; zero operands are caught in the FSM first.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    diff_xy = x_q - y_q;
    diff_yx = y_q - x_q;
    if (!x_q[0] && !y_q[0]) begin
      x_d = x_q >> 1;
      y_d = y_q >> 1;
      k_d = k_q + 6'd1;
    end else if (!x_q[0]) begin
      x_d = x_q >> 1;
    end else if (!y_q[0]) begin
      y_d = y_q >> 1;
    end else if (x_q >= y_q) begin
      x_d = diff_xy >> 1;
    end else begin
      y_d = diff_yx >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            x_q     <= a;
            y_q     <= b;
            k_q     <= '0;
            done_q  <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (x_q == 32'd0) begin
            result_q <= y_q << k_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else if (y_q == 32'd0) begin
            result_q <= x_q << k_q;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            x_q <= x_d;
            y_q <= y_d;
            k_q <= k_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_gcd.sv
// Scoreboard bench for gcd: driver pushes expected results, monitor pops on each done rise.
module tb_gcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_res;
  logic        done_prev = 1'b0;

  gcd dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .result(result), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, req, req);
    end
  endtask

  // Monitor: every rising done must present the oldest outstanding expected result.
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
    done_prev <= done;
  end

  // Issue one operation; optionally poke a stray start `poke_at` cycles into CALC.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] expv, input int poke_at,
                        input logic [31:0] pa, input logic [31:0] pb);
    int n;
    @(negedge clk);
    start = 1'b1;
    a = op_a;
    b = op_b;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    check("done_low_after_start", {31'd0, done}, 32'd0);
    check("result_held_at_start", result, prev_res);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (poke_at > 0 && n == poke_at) begin
        start = 1'b1;
        a = pa;
        b = pb;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    total++;
    if (n > 66) begin
      bad++;
      $display("FAIL latency: got %0d cycles expected <= 66", n);
    end
    prev_res = expv;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    prev_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic, then done and result must hold
    run_op(32'd48, 32'd18, 32'd6, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("done_hold", {31'd0, done}, 32'd1);
    check("result_hold", result, 32'd6);

    // Zero operands
    run_op(32'd0, 32'd7, 32'd7, 0, 0, 0);
    run_op(32'd7, 32'd0, 32'd7, 0, 0, 0);
    run_op(32'd0, 32'd0, 32'd0, 0, 0, 0);

    // Long-latency operands
    run_op(32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0);
    run_op(32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 0, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 0, 0, 0);

    // Back-to-back batch: start in the first DONE cycle
    run_op(32'd12, 32'd8, 32'd4, 0, 0, 0);
    run_op(32'd17, 32'd5, 32'd1, 0, 0, 0);
    run_op(32'd100, 32'd75, 32'd25, 0, 0, 0);
    run_op(32'd1071, 32'd462, 32'd21, 0, 0, 0);

    // Stray start during CALC is ignored
    run_op(32'd1071, 32'd462, 32'd21, 3, 32'd9, 32'd3);
    @(posedge clk);
    #1;
    check("ignored_start_result", result, 32'd21);

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_res = '0;
    repeat (10) @(posedge clk);
    #1;
    check("after_rst_idle_done", {31'd0, done}, 32'd0);
    run_op(32'd36, 32'd24, 32'd12, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
